axis_pkt_fifo_bridge: RTL
=========================

Name: axis_pkt_fifo_bridge

Overview:
Single-clock, store-and-forward AXI-Stream packet FIFO that sits between the 10G MAC RX stream and user logic. It generalises the MAC RX bridge in three ways: data width and depth are parameters, and each entry carries its own tkeep. The MAC is never backpressured; whole packets are dropped on overflow or on an errored frame. Only complete, good packets are ever presented on the master side, and per-packet counters are kept.

Parameters:
DATA_W, 64, stream data width in bits; must be a multiple of 8. KEEP_W = DATA_W/8 is derived.
DEPTH_LOG2, 10, FIFO depth in beats = 2**DEPTH_LOG2.
DROP_ON_ERR, 1, 1 = drop a frame whose tlast beat has s_axis_tuser=1; 0 = ignore tuser.
CNT_W, 32, width of the statistics counters.

Ports:
Clk156M25  in  1  clock.
RstMac_n  in  1  reset; asynchronous, active-low.
s_axis_tdata  in  DATA_W  MAC RX data.
s_axis_tkeep  in  KEEP_W  byte enables.
s_axis_tvalid  in  1  beat valid.
s_axis_tlast  in  1  last beat of a frame.
s_axis_tuser  in  1  frame error, sampled on the tlast beat only.
s_axis_tready  out  1  constant 1 out of reset; 0 while in reset.
m_axis_tdata  out  DATA_W  user-side data.
m_axis_tkeep  out  KEEP_W  stored tkeep for that beat.
m_axis_tvalid  out  1  user-side beat valid.
m_axis_tlast  out  1  user-side last beat.
m_axis_tready  in  1  user-side ready.
CntClr  in  1  synchronous clear of all counters.
RxPkt_Cnt  out  CNT_W  tlast beats received, dropped frames included.
TxPkt_Cnt  out  CNT_W  packets delivered.
DropPkt_Cnt  out  CNT_W  packets discarded.
FifoLevel  out  DEPTH_LOG2+1  committed beats not yet read.

Behaviour:
- Reset: pointers, counters, FifoLevel and all m_axis_* outputs are 0; the write FSM enters RESYNC.
- Entry format: {tlast, tkeep, tdata}, width DATA_W+KEEP_W+1.
- Write pointers:
  - wr_tmp advances on every written beat.
  - wr_cmt marks the end of the last good packet.
  - rd_ptr is the read address.
  - All pointers are DEPTH_LOG2+1 bits and wrap naturally.
  - full = (wr_tmp - rd_ptr) == 2**DEPTH_LOG2.
- Write FSM, evaluated only on beats with s_axis_tvalid=1:
  - RESYNC: beats are discarded and not counted. Go to ACCEPT on any cycle with s_axis_tvalid=0, or after a tlast beat. This stops a headless frame that was in flight at reset from being stored.
  - ACCEPT, beat arriving while full: the beat is not written, wr_tmp <= wr_cmt, go to DISCARD. If this beat is also tlast, count the drop and stay in ACCEPT.
  - ACCEPT, not full, non-last beat: write the beat, wr_tmp++.
  - ACCEPT, not full, tlast beat: write the beat. If (DROP_ON_ERR && tuser), then wr_tmp <= wr_cmt and DropPkt_Cnt++. Otherwise wr_cmt <= wr_tmp+1 and wr_tmp++.
  - DISCARD: beats are discarded. On the tlast beat, DropPkt_Cnt++ and go to ACCEPT.
- RxPkt_Cnt increments on every tlast beat seen outside RESYNC.
- Read side:
  - Committed data exists when rd_ptr != wr_cmt.
  - The sdp RAM has 1-cycle read latency, followed by one output register. Prefetch keeps the output register full whenever committed data exists.
  - When the FIFO is empty and the tlast beat of a packet is accepted at edge N, m_axis_tvalid=1 after edge N+2.
  - Throughput is 1 beat per cycle while m_axis_tready=1.
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
  - TxPkt_Cnt increments on tvalid && tready && tlast.
- Simultaneous events:
  - A commit and a read in the same cycle are both honoured.
  - The full check uses rd_ptr before that cycle's read, which is conservative by one beat.
  - A rollback never moves wr_tmp below wr_cmt, so committed packets are never corrupted.
- A packet longer than 2**DEPTH_LOG2 beats is always dropped.
- Counters wrap at 2**CNT_W. CntClr takes priority over a same-cycle increment.
- FifoLevel = wr_cmt - rd_ptr, registered, updated every cycle.
- Reset mid-packet: the partial write is lost, the output stream is cut without tlast, and the write FSM returns to RESYNC.

Decomposition:
- Package axis_fifo_pkg holds:
  - the write-FSM state encoding (RESYNC, ACCEPT, DISCARD);
  - the entry-width function f(DATA_W) = DATA_W+DATA_W/8+1;
  - the counter-width constant.
- One sub-module, axis_sdp_ram: single-clock simple dual-port RAM with registered read, parameters WIDTH and DEPTH_LOG2, inferring block RAM.

Test Plan:
All tests use DATA_W=64, DEPTH_LOG2=4.
1. Three back-to-back 4-beat good frames, last tkeep=8'h0F, m_axis_tready=1 → identical 12 beats out; last tkeep 8'h0F each; first m_axis_tvalid 2 cycles after the first tlast; RxPkt_Cnt=3, TxPkt_Cnt=3, DropPkt_Cnt=0.
2. A 5-beat frame with tuser=1 on tlast, then a 3-beat good frame → only the 3 beats emerge; DropPkt_Cnt=1; FifoLevel peaks at 3.
3. m_axis_tready=0, then 20-beat frame → dropped; DropPkt_Cnt=1; FifoLevel=0. A following 2-beat frame is delivered once ready=1.
4. m_axis_tready=0, then 16-beat frame → accepted; FifoLevel=16. Next frame dropped. Release ready → exactly 16 beats out, outputs stable during stalls.
5. Assert RstMac_n=0 during beat 3 of 6, release with beats 4–6 still arriving, then a 2-beat frame after a tvalid gap → tail beats discarded and uncounted; the 2-beat frame is delivered; RxPkt_Cnt=1.
6. CntClr pulsed in the same cycle as a tlast → all counters read 0 the next cycle.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the AXI-Stream store-and-forward packet FIFO.
package axis_fifo_pkg;

    localparam int unsigned CNT_W_DFLT = 32;

    typedef enum logic [1:0] {
        RESYNC  = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } WrState_t;

    // Stored entry is {tlast, tkeep, tdata}
    function automatic int unsigned entryWidth(input int unsigned dataW);
        return dataW + dataW / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_bridge_if.sv
// AXI-Stream beat bundle used on both sides of the packet FIFO.
interface axis_pkt_fifo_bridge_if #(
    parameter int unsigned DATA_W = 64
) ();
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_sdp_ram.sv
// Single-clock simple dual-port RAM with one-cycle registered read.
module axis_sdp_ram #(
    parameter int unsigned WIDTH      = 73,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  Clk156M25,
    input  logic                  WrEn,
    input  logic [DEPTH_LOG2-1:0] WrAddr,
    input  logic [WIDTH-1:0]      WrData,
    input  logic                  RdEn,
    input  logic [DEPTH_LOG2-1:0] RdAddr,
    output logic [WIDTH-1:0]      RdData
);
    logic [WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge Clk156M25) begin
        if (WrEn) mem[WrAddr] <= WrData;
    end

    // Read data holds while RdEn is low, so it doubles as a pipeline stage
    always_ff @(posedge Clk156M25) begin
        if (RdEn) RdData <= mem[RdAddr];
    end
endmodule

// File: rtl/axis_pkt_fifo_bridge.sv
// Store-and-forward packet FIFO between the MAC RX stream and user logic.
// Never backpressures the MAC; overflowing or errored frames are dropped whole.
module axis_pkt_fifo_bridge
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned DROP_ON_ERR = 1,
    parameter int unsigned CNT_W       = CNT_W_DFLT
) (
    input  logic                    Clk156M25,
    input  logic                    RstMac_n,
    axis_pkt_fifo_bridge_if.slave   s_axis,
    axis_pkt_fifo_bridge_if.master  m_axis,
    input  logic                    CntClr,
    output logic [CNT_W-1:0]        RxPkt_Cnt,
    output logic [CNT_W-1:0]        TxPkt_Cnt,
    output logic [CNT_W-1:0]        DropPkt_Cnt,
    output logic [DEPTH_LOG2:0]     FifoLevel
);
    localparam int unsigned KEEP_W  = DATA_W / 8;
    localparam int unsigned ENTRY_W = entryWidth(DATA_W);
    localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH_BEATS = {1'b1, {DEPTH_LOG2{1'b0}}};

    WrState_t            wrState;
    logic [PTR_W-1:0]    wrTmp;
    logic [PTR_W-1:0]    wrCmt;
    logic [PTR_W-1:0]    rdAddr;
    logic [PTR_W-1:0]    rdPtr;
    logic                sReadyQ;

    logic                full_c;
    logic                errBeat_c;
    logic                lastBeat_c;
    logic                ramWe_c;
    logic                rxInc_c;
    logic                dropInc_c;
    logic                txInc_c;
    logic                hasData_c;
    logic                outFree_c;
    logic                ramRe_c;

    logic [ENTRY_W-1:0]  ramWrData;
    logic [ENTRY_W-1:0]  ramRdData;
    logic                ramVld;
    logic                mValidQ;
    logic                mLastQ;
    logic [KEEP_W-1:0]   mKeepQ;
    logic [DATA_W-1:0]   mDataQ;

    // rdPtr is the consumer pointer (beats handed to the user); rdAddr runs
    // ahead by the prefetched beats, which stay protected until rdPtr passes.
    always_comb begin
        full_c     = (wrTmp - rdPtr) == DEPTH_BEATS;
        errBeat_c  = (DROP_ON_ERR != 0) && s_axis.tuser;
        lastBeat_c = s_axis.tvalid && s_axis.tlast;
        ramWe_c    = s_axis.tvalid && (wrState == ACCEPT) && !full_c;
        rxInc_c    = lastBeat_c && (wrState != RESYNC);
        dropInc_c  = lastBeat_c && ((wrState == DISCARD) ||
                                    ((wrState == ACCEPT) && (full_c || errBeat_c)));
        txInc_c    = mValidQ && m_axis.tready && mLastQ;
        hasData_c  = rdAddr != wrCmt;
        outFree_c  = !mValidQ || m_axis.tready;
        ramRe_c    = hasData_c && (!ramVld || outFree_c);
        ramWrData  = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end

    // Write-side packet FSM; a RESYNC exit needs an idle cycle or a frame end
    always_ff @(posedge Clk156M25 or negedge RstMac_n) begin
        if (!RstMac_n) begin
            wrState <= RESYNC;
            wrTmp   <= '0;
            wrCmt   <= '0;
        end else if (s_axis.tvalid) begin
            case (wrState)
                RESYNC: begin
                    if (s_axis.tlast) wrState <= ACCEPT;
                end
                ACCEPT: begin
                    if (full_c) begin
                        wrTmp <= wrCmt;
                        if (!s_axis.tlast) wrState <= DISCARD;
                    end else if (!s_axis.tlast) begin
                        wrTmp <= wrTmp + PTR_W'(1);
                    end else if (errBeat_c) begin
                        wrTmp <= wrCmt;
                    end else begin
                        wrCmt <= wrTmp + PTR_W'(1);
                        wrTmp <= wrTmp + PTR_W'(1);
                    end
                end
                DISCARD: begin
                    if (s_axis.tlast) wrState <= ACCEPT;
                end
                default: wrState <= RESYNC;
            endcase
        end else if (wrState == RESYNC) begin
            wrState <= ACCEPT;
        end
    end

    axis_sdp_ram #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uRam (
        .Clk156M25 (Clk156M25),
        .WrEn      (ramWe_c),
        .WrAddr    (wrTmp[DEPTH_LOG2-1:0]),
        .WrData    (ramWrData),
        .RdEn      (ramRe_c),
        .RdAddr    (rdAddr[DEPTH_LOG2-1:0]),
        .RdData    (ramRdData)
    );

    // Two-stage prefetch: RAM read register, then the output register
    always_ff @(posedge Clk156M25 or negedge RstMac_n) begin
        if (!RstMac_n) begin
            rdAddr  <= '0;
            rdPtr   <= '0;
            ramVld  <= 1'b0;
            mValidQ <= 1'b0;
            mLastQ  <= 1'b0;
            mKeepQ  <= '0;
            mDataQ  <= '0;
        end else begin
            if (ramRe_c) rdAddr <= rdAddr + PTR_W'(1);
            ramVld <= ramRe_c || (ramVld && !outFree_c);
            if (outFree_c) begin
                mValidQ <= ramVld;
                if (ramVld) {mLastQ, mKeepQ, mDataQ} <= ramRdData;
            end
            if (mValidQ && m_axis.tready) rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    // Statistics; a clear wins over a same-cycle increment
    always_ff @(posedge Clk156M25 or negedge RstMac_n) begin
        if (!RstMac_n) begin
            RxPkt_Cnt   <= '0;
            TxPkt_Cnt   <= '0;
            DropPkt_Cnt <= '0;
            FifoLevel   <= '0;
            sReadyQ     <= 1'b0;
        end else begin
            sReadyQ   <= 1'b1;
            FifoLevel <= wrCmt - rdPtr;
            if (CntClr) begin
                RxPkt_Cnt   <= '0;
                TxPkt_Cnt   <= '0;
                DropPkt_Cnt <= '0;
            end else begin
                if (rxInc_c)   RxPkt_Cnt   <= RxPkt_Cnt + CNT_W'(1);
                if (txInc_c)   TxPkt_Cnt   <= TxPkt_Cnt + CNT_W'(1);
                if (dropInc_c) DropPkt_Cnt <= DropPkt_Cnt + CNT_W'(1);
            end
        end
    end

    assign s_axis.tready = sReadyQ;
    assign m_axis.tvalid = mValidQ;
    assign m_axis.tlast  = mLastQ;
    assign m_axis.tkeep  = mKeepQ;
    assign m_axis.tdata  = mDataQ;
    assign m_axis.tuser  = 1'b0;
endmodule
